// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave responder over a word-addressed memory; WRAP bursts enabled by EI_AXI4_SLAVE_WRAP_EN.
// Latency: B one cycle after the last W beat; first R beat one cycle after the AR handshake.
// Backpressure: B/R fields held while valid and ready low; AW/AR accepted only when that side is idle.
module ei_axi4_slave_mem #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef EI_AXI4_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Transaction-level errors; a bad command never touches memory.
  function automatic logic cmd_bad(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic len_ok;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'(LSB)) || (burst == 2'b11) ||
           ((burst == 2'b10) && (!WRAP_EN || !len_ok));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step, mask, nxt;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    nxt  = addr + step;
    if (burst == 2'b00)
      nxt = addr;
    else if (burst == 2'b10)
      nxt = (addr & ~mask) | (nxt & mask);
    return nxt;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> LSB) < ADDR_W'(MEM_DEPTH);
  endfunction

  // Holds AW/AR ready low until the first edge after reset release.
  logic live_q;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // ---------------- write side ----------------
  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [7:0]        aw_len_q, w_beat_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic              aw_bad_q, w_err_q;
  logic              aw_hs, w_hs, w_last_beat, w_beat_err, w_we;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign w_last_beat = (w_beat_q == aw_len_q);
  assign w_beat_err  = !in_range(aw_addr_q) || (wlast != w_last_beat);
  assign w_we        = w_hs && !aw_bad_q && in_range(aw_addr_q);
  assign bid         = aw_id_q;
  assign bresp       = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = live_q;
        if (awvalid && live_q) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_bad_q   <= 1'b0;
      w_err_q    <= 1'b0;
      w_beat_q   <= '0;
    end else if (aw_hs) begin
      aw_id_q    <= awid;
      aw_addr_q  <= awaddr;
      aw_len_q   <= awlen;
      aw_size_q  <= awsize;
      aw_burst_q <= awburst;
      aw_bad_q   <= cmd_bad(awlen, awsize, awburst);
      w_err_q    <= cmd_bad(awlen, awsize, awburst);
      w_beat_q   <= '0;
    end else if (w_hs) begin
      aw_addr_q  <= addr_next(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
      w_beat_q   <= w_beat_q + 8'd1;
      w_err_q    <= w_err_q | w_beat_err;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int i = 0; i < STRB_W; i++)
        if (wstrb[i]) mem[aw_addr_q[LSB +: IDX_W]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------- read side ----------------
  r_state_t          r_state, r_state_nxt;
  logic [ADDR_W-1:0] ar_addr_q, rd_addr;
  logic [7:0]        ar_len_q, r_beat_q, rd_beat, rd_len;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic              ar_bad_q, rd_bad;
  logic              ar_hs, r_hs, r_final;

  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign r_final = (r_beat_q == ar_len_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = live_q;
        if (arvalid && live_q) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && r_final) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Address and attributes of the beat that will be presented next.
  always_comb begin
    rd_addr = addr_next(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
    rd_bad  = ar_bad_q;
    rd_beat = r_beat_q + 8'd1;
    rd_len  = ar_len_q;
    if (ar_hs) begin
      rd_addr = araddr;
      rd_bad  = cmd_bad(arlen, arsize, arburst);
      rd_beat = '0;
      rd_len  = arlen;
    end
  end

  // Read data is captured into a register so it stays put under backpressure
  // and reflects memory as it was before any same-cycle write.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rid        <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_bad_q   <= 1'b0;
      r_beat_q   <= '0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      rlast      <= 1'b0;
    end else if (ar_hs || (r_hs && !r_final)) begin
      if (ar_hs) begin
        rid        <= arid;
        ar_len_q   <= arlen;
        ar_size_q  <= arsize;
        ar_burst_q <= arburst;
      end
      ar_addr_q <= rd_addr;
      ar_bad_q  <= rd_bad;
      r_beat_q  <= rd_beat;
      rlast     <= (rd_beat == rd_len);
      if (rd_bad || !in_range(rd_addr)) begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end else begin
        rdata <= mem[rd_addr[LSB +: IDX_W]];
        rresp <= RESP_OKAY;
      end
    end else if (r_hs) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
    end
  end

endmodule
